// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control constants: FSM encoding, stage-bit indices and
// counter slot indices used by the controller and its bench-visible outputs.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int NUM_STAGES  = 4;
    localparam int PS1         = 0;
    localparam int PS2         = 1;
    localparam int PS3         = 2;
    localparam int PS4         = 3;

    localparam int DRAIN_CNT_W = 3;

    localparam int NUM_CNT     = 2;
    localparam int CNT_STALL   = 0;
    localparam int CNT_FLUSH   = 1;

    localparam logic [NUM_STAGES-1:0] STAGES_ALL  = '1;
    localparam logic [NUM_STAGES-1:0] STAGES_NONE = '0;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/flush/interrupt/halt controller for a 4-register pipeline: drives PC
// and pipeline-register enables/clears, drains before taking an interrupt.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_BITS     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_use_hazard,
    input  logic                branch_taken,
    input  logic                irq_req,
    input  logic                halt_wb,
    output logic                pc_en,
    output logic [3:0]          stage_en,
    output logic [3:0]          stage_clear,
    output logic                irq_take,
    output logic                halted,
    output logic [CNT_BITS-1:0] stall_cnt,
    output logic [CNT_BITS-1:0] flush_cnt
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES);

    state_t                 state_reg, state_next;
    logic [DRAIN_CNT_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic [NUM_CNT-1:0]     cnt_inc;
    logic [CNT_BITS-1:0]    cnt_val [NUM_CNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        pc_en          = 1'b0;
        stage_en       = STAGES_NONE;
        stage_clear    = STAGES_NONE;
        irq_take       = 1'b0;
        halted         = 1'b0;
        cnt_inc        = '0;

        if (rst) begin
            stage_clear = STAGES_ALL;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    pc_en    = 1'b1;
                    stage_en = STAGES_ALL;
                    if (halt_wb) begin
                        state_next = ST_HALTED;
                    end else if (branch_taken) begin
                        stage_clear[PS1]   = 1'b1;
                        stage_clear[PS2]   = 1'b1;
                        cnt_inc[CNT_FLUSH] = 1'b1;
                    end else if (load_use_hazard) begin
                        // Hold the dependent instruction in PS1, send a bubble down PS2.
                        pc_en              = 1'b0;
                        stage_en[PS1]      = 1'b0;
                        stage_clear[PS2]   = 1'b1;
                        cnt_inc[CNT_STALL] = 1'b1;
                    end else if (irq_req) begin
                        state_next     = ST_DRAIN;
                        drain_cnt_next = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    stage_en         = STAGES_ALL;
                    stage_clear[PS1] = 1'b1;
                    drain_cnt_next   = drain_cnt_reg - 1'b1;
                    if (halt_wb) begin
                        state_next = ST_HALTED;
                    end else if (drain_cnt_reg == DRAIN_CNT_W'(1)) begin
                        irq_take   = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                ST_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        sat_counter #(
            .WIDTH (CNT_BITS)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
        );
    end

    assign stall_cnt = cnt_val[CNT_STALL];
    assign flush_cnt = cnt_val[CNT_FLUSH];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes expected outputs from a
// rule-level model, a negedge monitor pops and compares every cycle.
module tb_pipeline_ctrl;

    localparam int CB   = 4;
    localparam int DC   = 3;
    localparam int CMAX = (1 << CB) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lu = 1'b0, br = 1'b0, irq = 1'b0, halt = 1'b0;
    logic          pc_en, irq_take, halted;
    logic [3:0]    stage_en, stage_clear;
    logic [CB-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(
        .DRAIN_CYCLES (DC),
        .CNT_BITS     (CB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .load_use_hazard (lu),
        .branch_taken    (br),
        .irq_req         (irq),
        .halt_wb         (halt),
        .pc_en           (pc_en),
        .stage_en        (stage_en),
        .stage_clear     (stage_clear),
        .irq_take        (irq_take),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       pc_en;
        logic [3:0] stage_en;
        logic [3:0] stage_clear;
        logic       irq_take;
        logic       halted;
        int         stall;
        int         flush;
        bit         cnt_known;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: "halted", "drain cycles still to go" and two event tallies.
    bit m_known = 0;
    bit m_halted = 0;
    int m_drain_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h @%0t", tag, fld, act, req, $time);
        end
    endtask

    task automatic drive(input bit r, input bit l, input bit b, input bit i, input bit h,
                         input string tag, output bit took);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; lu = l; br = b; irq = i; halt = h;
        e.tag = tag; e.cnt_known = m_known; e.stall = m_stall; e.flush = m_flush;
        e.pc_en = 1'b0; e.stage_en = 4'b0000; e.stage_clear = 4'b0000;
        e.irq_take = 1'b0; e.halted = 1'b0;
        if (r) begin
            e.stage_clear = 4'b1111;
            m_known = 1; m_halted = 0; m_drain_left = 0; m_stall = 0; m_flush = 0;
        end else if (m_halted) begin
            e.halted = 1'b1;
        end else if (m_drain_left > 0) begin
            e.stage_en = 4'b1111; e.stage_clear = 4'b0001;
            if (h) begin
                m_halted = 1; m_drain_left = 0;
            end else begin
                e.irq_take = (m_drain_left == 1);
                m_drain_left--;
            end
        end else begin
            e.pc_en = 1'b1; e.stage_en = 4'b1111;
            if (h) begin
                m_halted = 1;
            end else if (b) begin
                e.stage_clear = 4'b0011;
                if (m_flush < CMAX) m_flush++;
            end else if (l) begin
                e.pc_en = 1'b0; e.stage_en = 4'b1110; e.stage_clear = 4'b0010;
                if (m_stall < CMAX) m_stall++;
            end else if (i) begin
                m_drain_left = DC;
            end
        end
        took = e.irq_take;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, "pc_en",       32'(pc_en),       32'(mon_e.pc_en));
            chk(mon_e.tag, "stage_en",    32'(stage_en),    32'(mon_e.stage_en));
            chk(mon_e.tag, "stage_clear", 32'(stage_clear), 32'(mon_e.stage_clear));
            chk(mon_e.tag, "irq_take",    32'(irq_take),    32'(mon_e.irq_take));
            chk(mon_e.tag, "halted",      32'(halted),      32'(mon_e.halted));
            if (mon_e.cnt_known) begin
                chk(mon_e.tag, "stall_cnt", 32'(stall_cnt), 32'(mon_e.stall));
                chk(mon_e.tag, "flush_cnt", 32'(flush_cnt), 32'(mon_e.flush));
            end
        end
    end

    initial begin
        bit took;
        bit irq_lvl;
        bit r;

        drive(1, 0, 0, 0, 0, "reset", took);
        drive(1, 1, 1, 1, 0, "reset_busy", took);
        for (int k = 0; k < 6; k++) drive(0, 0, 0, 0, 0, "idle", took);

        drive(0, 1, 0, 0, 0, "load_use", took);
        drive(0, 0, 0, 0, 0, "after_lu", took);
        drive(0, 1, 1, 0, 0, "lu_and_br", took);
        drive(0, 0, 0, 0, 0, "after_br", took);

        // Interrupt with a branch inside the drain window.
        drive(0, 0, 0, 1, 0, "irq_accept", took);
        drive(0, 0, 0, 1, 0, "drain1", took);
        drive(0, 1, 1, 1, 0, "drain2_br", took);
        drive(0, 0, 0, 1, 0, "drain3", took);
        drive(0, 0, 0, 0, 0, "irq_done", took);

        // Branch blocks the interrupt; it is retried next cycle.
        drive(0, 0, 1, 1, 0, "irq_blocked", took);
        for (int k = 0; k < DC; k++) drive(0, 0, 0, 1, 0, "retry_drain", took);
        drive(0, 0, 0, 0, 0, "retry_done", took);

        // Reset mid-drain aborts without irq_take.
        drive(0, 0, 0, 1, 0, "irq_accept2", took);
        drive(0, 0, 0, 1, 0, "drain_a", took);
        drive(1, 0, 0, 1, 0, "rst_in_drain", took);
        drive(0, 0, 0, 0, 0, "post_abort", took);
        drive(0, 0, 0, 0, 0, "post_abort", took);

        // Halt on the last drain cycle suppresses irq_take.
        drive(0, 0, 0, 1, 0, "irq_accept3", took);
        drive(0, 0, 0, 1, 0, "drain_h1", took);
        drive(0, 0, 0, 1, 0, "drain_h2", took);
        drive(0, 0, 0, 1, 1, "drain_halt", took);
        for (int k = 0; k < 4; k++) drive(0, k[0], k[1], 1, k[0], "halted_hold", took);
        drive(1, 0, 0, 0, 0, "halt_reset", took);
        drive(0, 0, 0, 0, 0, "after_halt", took);

        // Saturation of the 4-bit counters.
        for (int k = 0; k < 20; k++) drive(0, 1, 0, 0, 0, "stall_sat", took);
        for (int k = 0; k < 20; k++) drive(0, 0, 1, 0, 0, "flush_sat", took);
        drive(0, 0, 0, 0, 0, "sat_done", took);
        drive(1, 0, 0, 0, 0, "reset_r", took);

        irq_lvl = 0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 59) == 0);
            if (!irq_lvl && ($urandom_range(0, 7) == 0)) irq_lvl = 1;
            drive(r, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, irq_lvl,
                  $urandom_range(0, 99) == 0, "rand", took);
            if (took || r) irq_lvl = 0;
        end
        drive(0, 0, 0, 0, 0, "tail", took);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_scoreboard actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
